// File: rtl/dc_token_pkg.sv
// dc_token_pkg: helpers shared by the writer and reader halves of the
// token/pointer dual-clock channel.
//   rotl1      - rotate a one-hot vector of width w left by one (MSB wraps to bit 0)
//   onehot2idx - index of the set bit of a one-hot vector
//   is_onehot  - true when exactly one bit is set
// Functions operate on a fixed-width carrier; callers zero-extend their
// BUFFER_WIDTH vectors into it and truncate results back down.
package dc_token_pkg;

  localparam int DC_BUFFER_WIDTH = 8;
  localparam int DC_MAX_W        = 64;

  typedef logic [DC_MAX_W-1:0] dc_vec_t;

  function automatic dc_vec_t rotl1(input dc_vec_t v, input int w);
    dc_vec_t r;
    r = '0;
    for (int i = 0; i < DC_MAX_W-1; i++)
      if (i < w-1) r[i+1] = v[i];
    r[0] = v[w-1];
    return r;
  endfunction

  function automatic int onehot2idx(input dc_vec_t v);
    int idx;
    idx = 0;
    for (int i = 0; i < DC_MAX_W; i++)
      if (v[i]) idx = idx | i;
    return idx;
  endfunction

  function automatic logic is_onehot(input dc_vec_t v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < DC_MAX_W; i++)
      cnt = cnt + int'(v[i]);
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/dc_ptr_sync.sv
// dc_ptr_sync: STAGES-deep flop synchronizer on a one-hot pointer, followed
// by a hold register that only accepts exactly-one-hot samples. Transient
// zero/two-hot values seen while the far side advances are ignored.
// Ports:
//   clk_i, rst_i - local clock, synchronous active-high reset
//   d_i          - asynchronous one-hot pointer from the far domain
//   q_o          - validated synchronized pointer (reset value 1)
module dc_ptr_sync import dc_token_pkg::*; #(
  parameter int WIDTH  = DC_BUFFER_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(1);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_q;
  dc_vec_t                      w_ext;
  logic                         w_valid;

  always_comb begin
    w_ext              = '0;
    w_ext[WIDTH-1:0]   = r_sync[STAGES-1];
    w_valid            = is_onehot(w_ext);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= {STAGES{RST_VAL}};
      r_q    <= RST_VAL;
    end else begin
      r_sync[0] <= d_i;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      if (w_valid) r_q <= r_sync[STAGES-1];
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/dc_token_writer.sv
// dc_token_writer: writer half of a token/pointer dual-clock channel.
// Accepts a valid/ready stream, stores each word in a slot register and
// advertises filled slots with a one-hot rotating write token.
// Ports:
//   clk_i, rst_i    - writer clock, synchronous active-high reset
//   data_i/valid_i  - payload in; ready_o high when a slot is free
//   write_token_o   - one-hot next slot to write (registered)
//   read_pointer_i  - far-side one-hot read pointer (asynchronous)
//   data_o          - flat slot array, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   level_o         - occupied slots as seen by the writer
module dc_token_writer import dc_token_pkg::*; #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_WIDTH = DC_BUFFER_WIDTH,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [BUFFER_WIDTH-1:0]            write_token_o,
  input  logic [BUFFER_WIDTH-1:0]            read_pointer_i,
  output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_o,
  output logic [$clog2(BUFFER_WIDTH)-1:0]    level_o
);

  localparam int LW = $clog2(BUFFER_WIDTH);

  logic [BUFFER_WIDTH-1:0]                 r_token;
  logic [BUFFER_WIDTH-1:0][DATA_WIDTH-1:0] r_data;
  logic [BUFFER_WIDTH-1:0]                 w_ptr_q, w_token_nxt;
  dc_vec_t                                 w_tok_ext, w_ptr_ext;
  logic [LW-1:0]                           w_widx, w_ridx;
  logic                                    w_full, w_accept;

  dc_ptr_sync #(.WIDTH(BUFFER_WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (read_pointer_i),
    .q_o   (w_ptr_q)
  );

  always_comb begin
    w_tok_ext                    = '0;
    w_tok_ext[BUFFER_WIDTH-1:0]  = r_token;
    w_ptr_ext                    = '0;
    w_ptr_ext[BUFFER_WIDTH-1:0]  = w_ptr_q;
    w_token_nxt = BUFFER_WIDTH'(rotl1(w_tok_ext, BUFFER_WIDTH));
    w_widx      = LW'(onehot2idx(w_tok_ext));
    w_ridx      = LW'(onehot2idx(w_ptr_ext));
  end

  // One slot is always left empty so full and empty are distinguishable.
  assign w_full   = (w_token_nxt == w_ptr_q);
  assign ready_o  = ~w_full & ~rst_i;
  assign w_accept = valid_i & ready_o;
  assign level_o  = w_widx - w_ridx;   // natural wrap gives mod BUFFER_WIDTH

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_token <= BUFFER_WIDTH'(1);
      r_data  <= '0;
    end else if (w_accept) begin
      r_data[w_widx] <= data_i;
      r_token        <= w_token_nxt;
    end
  end

  assign write_token_o = r_token;
  assign data_o        = r_data;

endmodule

// File: doc/dc_token_writer.md
# dc_token_writer

Writer half of the token/pointer dual-clock channel used on the cluster-to-SoC AXI ports, where each channel is carried as `*_writetoken` plus `*_readpointer`. The block accepts a valid/ready payload stream in its own clock domain and stores each word in a register slot. It advertises filled slots through a one-hot rotating write token. It consumes the far-side one-hot read pointer, which arrives asynchronously. One instance drives one AXI channel (AW, AR, W, R or B) toward the domain boundary.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits.
- `BUFFER_WIDTH`, default 8: number of slots and width of the token/pointer; power of two, ≥4.
- `SYNC_STAGES`, default 2: synchronizer depth on `read_pointer_i`; ≥2.

Ports (name, direction, width, meaning):
- `clk_i`  in  1  writer-domain clock; the only clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `data_i`  in  DATA_WIDTH  payload word.
- `valid_i`  in  1  payload valid.
- `ready_o`  out  1  slot free; a word transfers on `valid_i & ready_o`.
- `write_token_o`  out  BUFFER_WIDTH  one-hot pointer to the next slot to be written; registered.
- `read_pointer_i`  in  BUFFER_WIDTH  one-hot pointer to the reader's next slot; asynchronous to `clk_i`.
- `data_o`  out  BUFFER_WIDTH*DATA_WIDTH  flat slot array; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; registered.
- `level_o`  out  $clog2(BUFFER_WIDTH)  occupied slots as seen by the writer.

## Operation
- Slot index `w` = position of the set bit in `write_token_o`. Slot index `r` = position of the set bit in `ptr_q`, the validated synchronized read pointer.
- Empty: `write_token_o == ptr_q`. Full: `rotl(write_token_o,1) == ptr_q`. One slot always stays unused, so usable capacity is BUFFER_WIDTH-1.
- `ready_o = ~full & ~rst_i`. It depends on registers only; there is no combinational path from `valid_i` to `ready_o`.
- On an accepted transfer:
  - slot `w` of `data_o` takes `data_i`;
  - `write_token_o` rotates left by one, and bit BUFFER_WIDTH-1 wraps to bit 0.
- Unaccepted transfers change nothing, and slot contents not addressed by `w` never change.
- Pointer synchronizer: a chain of SYNC_STAGES flops on each bit, giving `ptr_s`.
  - `ptr_q` takes `ptr_s` only when `ptr_s` is exactly one-hot. Otherwise `ptr_q` holds, which covers transient two-hot or zero values seen during an advance.
- `level_o = (w - r) mod BUFFER_WIDTH`, computed in $clog2(BUFFER_WIDTH) bits with natural wrap. Range 0..BUFFER_WIDTH-1.
- Simultaneous accept and pointer advance: both take effect. `level_o` reflects both on the following cycle.
- Reset values:
  - `write_token_o` = 1;
  - all synchronizer flops and `ptr_q` = 1;
  - `data_o` = 0;
  - `level_o` = 0;
  - `ready_o` = 0 while `rst_i` is high, 1 on the first cycle after release.
- Reset mid-operation discards all stored words and returns every register to its reset value. Both sides of the boundary must be reset together; that is the system's responsibility.

## Timing
- Write latency: data accepted at edge N is visible in `data_o` slot `w` and reflected in `write_token_o` after edge N. Data and token update on the same edge. The reader's own token synchronization guarantees data is stable before the token is observed.
- Pointer latency: a stable change on `read_pointer_i` reaches `ptr_q` after SYNC_STAGES+1 rising edges. `ready_o` and `level_o` follow combinationally from `ptr_q`.
- When full, `ready_o` rises at most SYNC_STAGES+1 cycles after the reader advances.
- Throughput: one word per cycle while not full.

## Structure
- Shared package `dc_token_pkg` holds:
  - `rotl1` one-hot rotate function;
  - `onehot2idx` function;
  - `is_onehot` function;
  - default BUFFER_WIDTH constant (8), shared with the reader half.
- Sub-module `dc_ptr_sync`: SYNC_STAGES-deep, BUFFER_WIDTH-wide flop synchronizer plus the one-hot validation hold register (`ptr_q`). It is reused by the reader half for token synchronization.
- Slot array, token register, full/empty and level logic live in the top.

## Test plan
- Reset: hold `rst_i` 3 cycles with `valid_i`=1 → `ready_o`=0 during reset, then `write_token_o`=0x01, `level_o`=0, `ready_o`=1, `data_o`=0.
- Fill: `read_pointer_i`=0x01, write 0xA0..0xA6 back-to-back → `write_token_o`=0x80, `level_o`=7, `ready_o`=0. An 8th word held valid is not accepted and slot 7 stays 0.
- Drain/wrap: from full, set `read_pointer_i`=0x02 → after 3 cycles (SYNC_STAGES=2) `ready_o`=1 and `level_o`=6. The held word 0xA7 then lands in slot 7 and `write_token_o` wraps to 0x01.
- Glitch rejection: from `ptr_q`=0x02, drive `read_pointer_i`=0x06 for 5 cycles, then 0x04 → `ptr_q` stays 0x02 while the input is 0x06, then becomes 0x04 three cycles after 0x04 is applied. `level_o` changes only at that point.
- Simultaneous: with `level_o`=3, accept a word on the same edge the pointer advance reaches `ptr_q` → `level_o` stays 3 and the token advances by one.
- Reset mid-stream: with 5 words stored, assert `rst_i` for one cycle → all outputs return to reset values on the next edge.
